// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, next-PC select encodings, and the
// pc_sequencer state enum.
package cpu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NPC_W = 2;

    localparam logic [NPC_W-1:0] NPC_SEQ = 2'd0;
    localparam logic [NPC_W-1:0] NPC_BR  = 2'd1;
    localparam logic [NPC_W-1:0] NPC_J   = 2'd2;
    localparam logic [NPC_W-1:0] NPC_JR  = 2'd3;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } pc_seq_state_e;

endpackage

// File: rtl/npc_sel.sv
// Next-PC target mux. Redirect targets are word-aligned by clearing bits [1:0];
// the raw misalignment is reported so the caller can flag it.
module npc_sel
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0]  pc,
    input  logic [NPC_W-1:0] npc_op,
    input  logic [XLEN-1:0]  branch_address,
    input  logic [XLEN-1:0]  jump_address,
    input  logic [XLEN-1:0]  rd0,
    output logic [XLEN-1:0]  next_pc,
    output logic             misaligned
);

    logic [XLEN-1:0] raw;

    always_comb begin
        raw = pc + XLEN'(4);
        case (npc_op)
            NPC_BR:  raw = branch_address;
            NPC_J:   raw = jump_address;
            NPC_JR:  raw = rd0;
            default: raw = pc + XLEN'(4);
        endcase
        next_pc    = {raw[XLEN-1:2], 2'b00};
        misaligned = |raw[1:0];
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: boots, advances sequentially, stalls on hazards and
// back-pressure, and redirects with pipeline flushes on taken control flow.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BOOT_WAIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_ready,
    input  logic             hazard_stall,
    input  logic             ex_valid,
    input  logic [NPC_W-1:0] ex_npc_op,
    input  logic             zero,
    input  logic [XLEN-1:0]  branch_address,
    input  logic [XLEN-1:0]  jump_address,
    input  logic [XLEN-1:0]  rd0,
    output logic [XLEN-1:0]  pc,
    output logic             fetch_valid,
    output logic [NPC_W-1:0] npc_op,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [15:0]      redirect_count,
    output logic             misalign_err
);

    localparam int unsigned CNT_W = 4;

    pc_seq_state_e    state, next_state;
    logic [CNT_W-1:0] boot_cnt;
    logic             take;
    logic             redirect;
    logic             pc_load;
    logic [XLEN-1:0]  next_pc;
    logic             misaligned;

    assign take = ex_valid && ((ex_npc_op == NPC_J) || (ex_npc_op == NPC_JR) ||
                               ((ex_npc_op == NPC_BR) && zero));

    npc_sel u_npc_sel (
        .pc             (pc),
        .npc_op         (npc_op),
        .branch_address (branch_address),
        .jump_address   (jump_address),
        .rd0            (rd0),
        .next_pc        (next_pc),
        .misaligned     (misaligned)
    );

    // Next state and per-cycle control; a take in RUN/HOLD overrides stalls.
    always_comb begin
        next_state  = state;
        npc_op      = NPC_SEQ;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        fetch_valid = 1'b0;
        pc_load     = 1'b0;
        redirect    = 1'b0;
        case (state)
            BOOT: begin
                if (boot_cnt == CNT_W'(BOOT_WAIT - 1)) next_state = RUN;
            end
            RUN, HOLD: begin
                fetch_valid = 1'b1;
                if (take) begin
                    npc_op     = ex_npc_op;
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    pc_load    = 1'b1;
                    redirect   = 1'b1;
                    next_state = FLUSH;
                end else if (state == HOLD) begin
                    // pc is not advanced on the exit cycle
                    if (!hazard_stall) next_state = RUN;
                end else if (hazard_stall) begin
                    next_state = HOLD;
                end else if (imem_ready) begin
                    pc_load = 1'b1;
                end
            end
            FLUSH: begin
                flush_ifid = 1'b1;
                next_state = RUN;
            end
            default: next_state = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= BOOT;
            boot_cnt       <= '0;
            pc             <= RESET_PC;
            redirect_count <= '0;
            misalign_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (pc_load) pc <= next_pc;
            if (state == BOOT) boot_cnt <= boot_cnt + CNT_W'(1);
            else boot_cnt <= '0;
            if (redirect && (redirect_count != 16'hFFFF))
                redirect_count <= redirect_count + 16'd1;
            if (redirect && misaligned) misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (RESET_PC=0, BOOT_WAIT=2).
module tb_pc_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        hazard_stall;
    logic        ex_valid;
    logic [1:0]  ex_npc_op;
    logic        zero;
    logic [31:0] branch_address;
    logic [31:0] jump_address;
    logic [31:0] rd0;
    logic [31:0] pc;
    logic        fetch_valid;
    logic [1:0]  npc_op;
    logic        flush_ifid;
    logic        flush_idex;
    logic [15:0] redirect_count;
    logic        misalign_err;

    int passed = 0;
    int total  = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .BOOT_WAIT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_ready     (imem_ready),
        .hazard_stall   (hazard_stall),
        .ex_valid       (ex_valid),
        .ex_npc_op      (ex_npc_op),
        .zero           (zero),
        .branch_address (branch_address),
        .jump_address   (jump_address),
        .rd0            (rd0),
        .pc             (pc),
        .fetch_valid    (fetch_valid),
        .npc_op         (npc_op),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .redirect_count (redirect_count),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid  = 1'b0;
        ex_npc_op = NPC_SEQ;
        zero      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        imem_ready = 1'b1;
        hazard_stall = 1'b0;
        clear_ex();
        branch_address = '0;
        jump_address = '0;
        rd0 = '0;
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_cnt", 32'(redirect_count), 32'd0);
        chk("rst_mis", 32'(misalign_err), 32'd0);

        // boot: rst released, first edge with rst low still in BOOT
        tick(); rst = 1'b0; #1;
        tick(); chk("boot1_fv", 32'(fetch_valid), 32'd0);
        tick(); chk("boot2_fv", 32'(fetch_valid), 32'd1); chk("boot2_pc", pc, 32'h0);
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);
        tick(); tick(); chk("seq_pc10", pc, 32'h10);

        // taken branch at 0x10 to 0x40
        ex_valid = 1'b1; ex_npc_op = NPC_BR; zero = 1'b1; branch_address = 32'h40; #1;
        chk("br_fl_ifid", 32'(flush_ifid), 32'd1);
        chk("br_fl_idex", 32'(flush_idex), 32'd1);
        chk("br_npc_op", 32'(npc_op), 32'd1);
        tick(); clear_ex(); #1;
        chk("br_tgt_pc", pc, 32'h40);
        chk("br_flush_fv", 32'(fetch_valid), 32'd0);
        chk("br_flush_ifid", 32'(flush_ifid), 32'd1);
        chk("br_flush_idex", 32'(flush_idex), 32'd0);
        chk("br_count", 32'(redirect_count), 32'd1);
        tick(); chk("br_run_pc", pc, 32'h40); chk("br_run_fv", 32'(fetch_valid), 32'd1);
        tick(); chk("br_next_pc", pc, 32'h44);

        // not-taken branch
        ex_valid = 1'b1; ex_npc_op = NPC_BR; zero = 1'b0; #1;
        chk("nt_flush", 32'(flush_ifid), 32'd0);
        chk("nt_npc_op", 32'(npc_op), 32'd0);
        tick(); clear_ex(); #1;
        chk("nt_pc", pc, 32'h48);
        chk("nt_count", 32'(redirect_count), 32'd1);

        // jump to 0x20
        ex_valid = 1'b1; ex_npc_op = NPC_J; jump_address = 32'h20; #1;
        chk("j_npc_op", 32'(npc_op), 32'd2);
        tick(); clear_ex(); #1;
        chk("j_pc", pc, 32'h20);
        tick(); chk("j_run_pc", pc, 32'h20);

        // hazard stall for 3 cycles at 0x20
        hazard_stall = 1'b1; #1;
        chk("st_fv", 32'(fetch_valid), 32'd1);
        tick(); chk("st_pc1", pc, 32'h20);
        tick(); chk("st_pc2", pc, 32'h20);
        tick(); chk("st_pc3", pc, 32'h20); chk("st_hold_fv", 32'(fetch_valid), 32'd1);
        hazard_stall = 1'b0;
        tick(); chk("st_exit_pc", pc, 32'h20);
        tick(); chk("st_adv_pc", pc, 32'h24);

        // jr to misaligned 0x103 together with a stall
        hazard_stall = 1'b1; ex_valid = 1'b1; ex_npc_op = NPC_JR; rd0 = 32'h103; #1;
        chk("jr_fl_idex", 32'(flush_idex), 32'd1);
        chk("jr_npc_op", 32'(npc_op), 32'd3);
        tick(); clear_ex(); hazard_stall = 1'b0; #1;
        chk("jr_pc", pc, 32'h100);
        chk("jr_fv", 32'(fetch_valid), 32'd0);
        chk("jr_mis", 32'(misalign_err), 32'd1);
        chk("jr_count", 32'(redirect_count), 32'd3);
        tick(); chk("jr_run_pc", pc, 32'h100);
        tick(); chk("jr_adv_pc", pc, 32'h104); chk("jr_mis_sticky", 32'(misalign_err), 32'd1);

        // sequential wrap
        ex_valid = 1'b1; ex_npc_op = NPC_J; jump_address = 32'hFFFF_FFFC; #1;
        tick(); clear_ex(); #1;
        tick(); chk("wrap_pre", pc, 32'hFFFF_FFFC);
        tick(); chk("wrap_pc", pc, 32'h0);

        // instruction memory back-pressure holds pc
        imem_ready = 1'b0; #1;
        tick(); chk("bp_pc", pc, 32'h0); chk("bp_fv", 32'(fetch_valid), 32'd1);
        imem_ready = 1'b1;
        tick(); chk("bp_rel_pc", pc, 32'h4);

        // reset during FLUSH
        ex_valid = 1'b1; ex_npc_op = NPC_J; jump_address = 32'h80; #1;
        tick(); clear_ex(); #1;
        chk("fl_pre_pc", pc, 32'h80);
        rst = 1'b1; #1;
        chk("fr_pc", pc, 32'h0);
        chk("fr_fv", 32'(fetch_valid), 32'd0);
        chk("fr_ifid", 32'(flush_ifid), 32'd0);
        chk("fr_idex", 32'(flush_idex), 32'd0);
        chk("fr_npc_op", 32'(npc_op), 32'd0);
        chk("fr_count", 32'(redirect_count), 32'd0);
        chk("fr_mis", 32'(misalign_err), 32'd0);
        tick(); rst = 1'b0;
        tick(); chk("fr_boot_fv", 32'(fetch_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
